// File: rtl/guess_key_sequencer_if.sv
// Button-interface bundle between a key-sequence source and its consumer.
// The sequencer drives the key/enter pulses and status; the requester drives start/digits/len.
interface guess_key_sequencer_if #(
    parameter int MAX_DIGITS = 5,
    parameter int LEN_W      = 3
);
    logic                      start;
    logic [2*MAX_DIGITS-1:0]   digits;
    logic [LEN_W-1:0]          len;
    logic                      busy;
    logic                      done;
    logic                      I1;
    logic                      I2;
    logic                      I3;
    logic                      I4;
    logic                      enter;

    modport master (
        output start, digits, len,
        input  busy, done, I1, I2, I3, I4, enter
    );

    modport slave (
        input  start, digits, len,
        output busy, done, I1, I2, I3, I4, enter
    );
endinterface

// File: rtl/guess_key_sequencer.sv
// Replays a captured digit string as timed single-key pulses on I1..I4 followed by one enter pulse.
// All outputs come straight from flops; one FSM owns every register.
module guess_key_sequencer #(
    parameter int MAX_DIGITS   = 5,
    parameter int LEN_W        = 3,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    guess_key_sequencer_if.slave         bus
);

    localparam int DW     = 2 * MAX_DIGITS;
    localparam int PH_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]  PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
    localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(GAP_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_ZERO    = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO   = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);
    localparam logic [LEN_W-1:0] MAX_LEN    = LEN_W'(MAX_DIGITS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY       = 3'd1,
        KEY_GAP   = 3'd2,
        ENTER     = 3'd3,
        ENTER_GAP = 3'd4
    } state_t;

    state_t            state_r;
    logic [PH_W-1:0]   phase_r;
    logic [LEN_W-1:0]  idx_r;
    logic [LEN_W-1:0]  n_r;
    logic [DW-1:0]     pend_r;
    logic              busy_r;
    logic              done_r;
    logic [3:0]        key_r;
    logic              enter_r;

    // 2-bit digit code (00=1 .. 11=4) to one-hot key lines {I4,I3,I2,I1}.
    function automatic logic [3:0] key_onehot(input logic [1:0] code);
        logic [3:0] oh;
        case (code)
            2'b00:   oh = 4'b0001;
            2'b01:   oh = 4'b0010;
            2'b10:   oh = 4'b0100;
            2'b11:   oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Sequencer FSM: phase_r counts cycles within a state, pend_r holds not-yet-sent digits LSB-first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            phase_r <= PH_ZERO;
            idx_r   <= LEN_ZERO;
            n_r     <= LEN_ZERO;
            pend_r  <= {DW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            key_r   <= 4'b0000;
            enter_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    phase_r <= PH_ZERO;
                    idx_r   <= LEN_ZERO;
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        pend_r <= {2'b00, bus.digits[DW-1:2]};
                        if (bus.len > MAX_LEN) begin
                            n_r <= MAX_LEN;
                        end else begin
                            n_r <= bus.len;
                        end
                        if (bus.len == LEN_ZERO) begin
                            state_r <= ENTER;
                            enter_r <= 1'b1;
                        end else begin
                            state_r <= KEY;
                            key_r   <= key_onehot(bus.digits[1:0]);
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                KEY: begin
                    if (phase_r == PULSE_LAST) begin
                        state_r <= KEY_GAP;
                        key_r   <= 4'b0000;
                        phase_r <= PH_ZERO;
                    end else begin
                        phase_r <= phase_r + PH_ONE;
                    end
                end
                KEY_GAP: begin
                    if (phase_r == GAP_LAST) begin
                        phase_r <= PH_ZERO;
                        // n_r is at least 1 here, so n_r-1 is the last digit index.
                        if (idx_r == n_r - LEN_ONE) begin
                            state_r <= ENTER;
                            enter_r <= 1'b1;
                        end else begin
                            state_r <= KEY;
                            idx_r   <= idx_r + LEN_ONE;
                            key_r   <= key_onehot(pend_r[1:0]);
                            pend_r  <= {2'b00, pend_r[DW-1:2]};
                        end
                    end else begin
                        phase_r <= phase_r + PH_ONE;
                    end
                end
                ENTER: begin
                    if (phase_r == PULSE_LAST) begin
                        state_r <= ENTER_GAP;
                        enter_r <= 1'b0;
                        phase_r <= PH_ZERO;
                    end else begin
                        phase_r <= phase_r + PH_ONE;
                    end
                end
                ENTER_GAP: begin
                    if (phase_r == GAP_LAST) begin
                        state_r <= IDLE;
                        phase_r <= PH_ZERO;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        phase_r <= phase_r + PH_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    phase_r <= PH_ZERO;
                    idx_r   <= LEN_ZERO;
                    busy_r  <= 1'b0;
                    key_r   <= 4'b0000;
                    enter_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.I1    = key_r[0];
    assign bus.I2    = key_r[1];
    assign bus.I3    = key_r[2];
    assign bus.I4    = key_r[3];
    assign bus.enter = enter_r;

endmodule

// File: tb/tb_guess_key_sequencer.sv
// Directed bench for guess_key_sequencer: default-timing instance plus a 1/1-cycle timing instance.
module tb_guess_key_sequencer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   i4_rises;
    logic i4_prev;

    guess_key_sequencer_if #(.MAX_DIGITS(5), .LEN_W(3)) if0 ();
    guess_key_sequencer_if #(.MAX_DIGITS(5), .LEN_W(3)) if1 ();

    guess_key_sequencer #(.MAX_DIGITS(5), .LEN_W(3), .PULSE_CYCLES(2), .GAP_CYCLES(2)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    guess_key_sequencer #(.MAX_DIGITS(5), .LEN_W(3), .PULSE_CYCLES(1), .GAP_CYCLES(1)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges of I4 on the default instance.
    always @(negedge clk) begin
        if (if0.I4 === 1'b1 && i4_prev === 1'b0) i4_rises <= i4_rises + 1;
        i4_prev <= if0.I4;
    end

    // Observed vector {busy, done, enter, I4, I3, I2, I1}.
    function automatic logic [6:0] sample(input int which);
        if (which == 0) return {if0.busy, if0.done, if0.enter, if0.I4, if0.I3, if0.I2, if0.I1};
        else            return {if1.busy, if1.done, if1.enter, if1.I4, if1.I3, if1.I2, if1.I1};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b ({busy,done,enter,I4,I3,I2,I1})", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input int which, input logic [9:0] dv, input logic [2:0] ln);
        if (which == 0) begin
            if0.digits = dv; if0.len = ln; if0.start = 1'b1;
        end else begin
            if1.digits = dv; if1.len = ln; if1.start = 1'b1;
        end
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        if1.start = 1'b0;
    endtask

    // Expected waveform: each slot is pc cycles of one line high then gc low cycles; slot n is enter.
    task automatic watch(input int which, input logic [9:0] dv, input int n, input int pc,
                         input int gc, input int limit, input bit poke, input string tag);
        int total;
        int slot;
        int off;
        logic [6:0] e;
        logic [3:0] one;
        logic [1:0] d;
        one   = 4'b0001;
        total = (n + 1) * (pc + gc);
        if (limit > 0 && limit < total) total = limit;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            slot = k / (pc + gc);
            off  = k % (pc + gc);
            e    = 7'b1000000;
            if (off < pc) begin
                if (slot < n) begin
                    d       = dv[2*slot +: 2];
                    e[3:0]  = one << d;
                end else begin
                    e[4] = 1'b1;
                end
            end
            chk($sformatf("%s[%0d]", tag, k), sample(which), e);
            if (poke && k == 5) begin
                if0.start = 1'b1; if0.digits = 10'h3FF; if0.len = 3'd1;
            end
            if (poke && k == 7) if0.start = 1'b0;
        end
    endtask

    task automatic check_done(input int which, input string tag);
        @(negedge clk);
        chk({tag, "_done"}, sample(which), 7'b0100000);
    endtask

    task automatic check_idle(input int which, input string tag);
        @(negedge clk);
        chk({tag, "_idle"}, sample(which), 7'b0000000);
    endtask

    initial begin
        int i4_base;
        n_checks = 0;
        n_fail   = 0;
        i4_rises = 0;
        if0.start = 1'b0; if0.digits = 10'h000; if0.len = 3'd0;
        if1.start = 1'b0; if1.digits = 10'h000; if1.len = 3'd0;

        // Reset, with start held high to show reset wins.
        reset = 1'b1;
        if0.start = 1'b1; if0.len = 3'd2;
        @(negedge clk);
        chk("reset0", sample(0), 7'b0000000);
        chk("reset1", sample(1), 7'b0000000);
        @(negedge clk);
        reset = 1'b0;
        if0.start = 1'b0;
        check_idle(0, "post_reset0");
        check_idle(1, "post_reset1");

        // 1: digits 1,2,3,4
        launch(0, 10'h0E4, 3'd4);
        watch(0, 10'h0E4, 4, 2, 2, 0, 1'b0, "t1");
        check_done(0, "t1");
        check_idle(0, "t1");

        // 2: codes 11,11,01,00,10 -> keys 4,4,2,1,3
        i4_base = i4_rises;
        launch(0, 10'b10_00_01_11_11, 3'd5);
        watch(0, 10'b10_00_01_11_11, 5, 2, 2, 0, 1'b0, "t2");
        check_done(0, "t2");
        check_idle(0, "t2");
        chk_int("t2_i4_rises", i4_rises - i4_base, 2);

        // 3: len=0 sends enter only
        launch(0, 10'h3FF, 3'd0);
        watch(0, 10'h3FF, 0, 2, 2, 0, 1'b0, "t3");
        check_done(0, "t3");
        check_idle(0, "t3");

        // 4: len=7 clamps to 5; start mid-sequence ignored; start in done cycle accepted
        launch(0, 10'b01_11_01_10_00, 3'd7);
        watch(0, 10'b01_11_01_10_00, 5, 2, 2, 0, 1'b1, "t4a");
        check_done(0, "t4a");
        launch(0, 10'h01B, 3'd2);
        watch(0, 10'h01B, 2, 2, 2, 0, 1'b0, "t4b");
        check_done(0, "t4b");
        check_idle(0, "t4b_1");
        check_idle(0, "t4b_2");

        // 5: reset during third key pulse, then a fresh full sequence
        launch(0, 10'h0E4, 3'd4);
        watch(0, 10'h0E4, 4, 2, 2, 9, 1'b0, "t5a");
        reset = 1'b1;
        @(negedge clk);
        chk("t5_after_reset", sample(0), 7'b0000000);
        reset = 1'b0;
        check_idle(0, "t5_1");
        check_idle(0, "t5_2");
        launch(0, 10'h0B1, 3'd3);
        watch(0, 10'h0B1, 3, 2, 2, 0, 1'b0, "t5b");
        check_done(0, "t5b");
        check_idle(0, "t5b");

        // 6: 1/1 timing, digits 1,1,1
        launch(1, 10'h000, 3'd3);
        watch(1, 10'h000, 3, 1, 1, 0, 1'b0, "t6");
        check_done(1, "t6");
        check_idle(1, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
